// File: rtl/aq32_regfile_pkg.sv
`default_nettype none
// ============================================================================
// aq32_regfile_pkg : shared sizes, FSM states and port-A grant encoding
// Revision: 1.0
// ============================================================================
package aq32_regfile_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_COUNT  = 32;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_RUN   = 2'd1,
      ST_ACK   = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_CORE = 2'd1,
      GNT_DBG  = 2'd2,
      GNT_CLR  = 2'd3
   } grant_t;

endpackage
`default_nettype wire

// File: rtl/aq32_regfile_arb.sv
`default_nettype none
// ============================================================================
// aq32_regfile_arb : port-A grant decision and debug starvation counter
// Revision: 1.0
// ============================================================================
module aq32_regfile_arb
   import aq32_regfile_pkg::*;
#(
   parameter int STARVE_LIMIT = 8
) (
   input  logic   clk,
   input  logic   reset_n,
   input  state_t state,
   input  logic   core_wr_en,
   input  logic   dbg_req,
   output grant_t grant,
   output logic   core_stall
);

   localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

   logic [7:0] r_starve_cnt;
   logic       w_forced;

   assign w_forced = dbg_req && (r_starve_cnt >= LIMIT);

   always_comb begin
      grant      = GNT_NONE;
      core_stall = 1'b0;
      case (state)
         ST_CLEAR: begin
            grant      = GNT_CLR;
            core_stall = 1'b1;
         end
         ST_RUN: begin
            if (w_forced) begin
               grant      = GNT_DBG;
               core_stall = 1'b1;
            end else if (core_wr_en) begin
               grant = GNT_CORE;
            end else if (dbg_req) begin
               grant = GNT_DBG;
            end
         end
         // Debug has just completed; only the core may use port A here.
         ST_ACK: begin
            if (core_wr_en) grant = GNT_CORE;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_starve_cnt <= '0;
      end else if (!dbg_req || (grant == GNT_DBG)) begin
         r_starve_cnt <= '0;
      end else if ((state == ST_RUN) && (r_starve_cnt != 8'hFF)) begin
         r_starve_cnt <= r_starve_cnt + 8'd1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/aq32_regfile_ctrl.sv
`default_nettype none
// ============================================================================
// aq32_regfile_ctrl : register-file sequencer, port-A arbiter, port-B forwarder
// Optional zero-fill after reset enabled by AQ32_REGFILE_CLEAR_EN.  Revision: 1.0
// ============================================================================
module aq32_regfile_ctrl
   import aq32_regfile_pkg::*;
#(
   parameter int WIDTH        = 32,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   output logic                  busy,
   output logic                  core_stall,
   input  logic                  core_wr_en,
   input  logic [REG_ADDR_W-1:0] core_wr_addr,
   input  logic [WIDTH-1:0]      core_wr_data,
   input  logic [REG_ADDR_W-1:0] core_rd_addr,
   output logic [WIDTH-1:0]      core_rd_data,
   input  logic                  dbg_req,
   input  logic                  dbg_we,
   input  logic [REG_ADDR_W-1:0] dbg_addr,
   input  logic [WIDTH-1:0]      dbg_wrdata,
   output logic                  dbg_ack,
   output logic [WIDTH-1:0]      dbg_rddata,
   output logic [REG_ADDR_W-1:0] ram_a_addr,
   output logic [WIDTH-1:0]      ram_a_wrdata,
   output logic [WIDTH-1:0]      ram_a_wren,
   input  logic [WIDTH-1:0]      ram_a_rddata,
   output logic [REG_ADDR_W-1:0] ram_b_addr,
   input  logic [WIDTH-1:0]      ram_b_rddata
);

   state_t r_state;
   grant_t w_grant;
   logic   w_fwd;

   aq32_regfile_arb #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_arb (
      .clk        (clk),
      .reset_n    (reset_n),
      .state      (r_state),
      .core_wr_en (core_wr_en),
      .dbg_req    (dbg_req),
      .grant      (w_grant),
      .core_stall (core_stall)
   );

`ifdef AQ32_REGFILE_CLEAR_EN
   logic [REG_ADDR_W-1:0] r_clr_cnt;
   assign busy = (r_state == ST_CLEAR);
`else
   assign busy = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
`ifdef AQ32_REGFILE_CLEAR_EN
         r_state   <= ST_CLEAR;
         r_clr_cnt <= '0;
`else
         r_state   <= ST_RUN;
`endif
         dbg_ack    <= 1'b0;
         dbg_rddata <= '0;
      end else begin
         dbg_ack <= 1'b0;
         case (r_state)
`ifdef AQ32_REGFILE_CLEAR_EN
            ST_CLEAR: begin
               r_clr_cnt <= r_clr_cnt + REG_ADDR_W'(1);
               if (r_clr_cnt == REG_ADDR_W'(REG_COUNT - 1)) r_state <= ST_RUN;
            end
`endif
            ST_RUN: begin
               if (w_grant == GNT_DBG) begin
                  r_state <= ST_ACK;
                  dbg_ack <= 1'b1;
                  // x0 reads as zero regardless of what the RAM holds there.
                  if (!dbg_we) dbg_rddata <= (dbg_addr == '0) ? '0 : ram_a_rddata;
               end
            end
            ST_ACK:  r_state <= ST_RUN;
            default: r_state <= ST_RUN;
         endcase
      end
   end

   always_comb begin
      ram_a_addr   = '0;
      ram_a_wrdata = '0;
      ram_a_wren   = '0;
      case (w_grant)
         GNT_CORE: begin
            ram_a_addr   = core_wr_addr;
            ram_a_wrdata = core_wr_data;
            ram_a_wren   = {WIDTH{core_wr_addr != '0}};
         end
         GNT_DBG: begin
            ram_a_addr   = dbg_addr;
            ram_a_wrdata = dbg_wrdata;
            ram_a_wren   = {WIDTH{dbg_we && (dbg_addr != '0)}};
         end
`ifdef AQ32_REGFILE_CLEAR_EN
         GNT_CLR: begin
            ram_a_addr = r_clr_cnt;
            ram_a_wren = {WIDTH{1'b1}};
         end
`endif
         default: ;
      endcase
   end

   assign ram_b_addr   = core_rd_addr;
   assign w_fwd        = (w_grant == GNT_CORE) && (core_wr_addr == core_rd_addr);
   assign core_rd_data = (core_rd_addr == '0) ? '0 :
                         w_fwd                ? core_wr_data : ram_b_rddata;

endmodule
`default_nettype wire

// File: tb/tb_aq32_regfile_ctrl.sv
`default_nettype none
// ============================================================================
// tb_aq32_regfile_ctrl : directed self-checking bench with a behavioural RAM
// Revision: 1.0
// ============================================================================
module tb_aq32_regfile_ctrl;

`ifdef AQ32_REGFILE_CLEAR_EN
   localparam logic CLR_EN = 1'b1;
`else
   localparam logic CLR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        busy, core_stall;
   logic        core_wr_en = 1'b0;
   logic [4:0]  core_wr_addr = '0;
   logic [31:0] core_wr_data = '0;
   logic [4:0]  core_rd_addr = '0;
   logic [31:0] core_rd_data;
   logic        dbg_req = 1'b0;
   logic        dbg_we = 1'b0;
   logic [4:0]  dbg_addr = '0;
   logic [31:0] dbg_wrdata = '0;
   logic        dbg_ack;
   logic [31:0] dbg_rddata;
   logic [4:0]  ram_a_addr;
   logic [31:0] ram_a_wrdata, ram_a_wren, ram_a_rddata;
   logic [4:0]  ram_b_addr;
   logic [31:0] ram_b_rddata;

   logic        ram_load = 1'b1;
   logic [31:0] mem [32];
   int          n_checks = 0;
   int          n_fail = 0;

   aq32_regfile_ctrl #(.WIDTH(32), .STARVE_LIMIT(8)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .busy         (busy),
      .core_stall   (core_stall),
      .core_wr_en   (core_wr_en),
      .core_wr_addr (core_wr_addr),
      .core_wr_data (core_wr_data),
      .core_rd_addr (core_rd_addr),
      .core_rd_data (core_rd_data),
      .dbg_req      (dbg_req),
      .dbg_we       (dbg_we),
      .dbg_addr     (dbg_addr),
      .dbg_wrdata   (dbg_wrdata),
      .dbg_ack      (dbg_ack),
      .dbg_rddata   (dbg_rddata),
      .ram_a_addr   (ram_a_addr),
      .ram_a_wrdata (ram_a_wrdata),
      .ram_a_wren   (ram_a_wren),
      .ram_a_rddata (ram_a_rddata),
      .ram_b_addr   (ram_b_addr),
      .ram_b_rddata (ram_b_rddata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_val(input int i);
      return 32'hA5A5_0000 | 32'(i);
   endfunction

   // Distributed RAM: asynchronous reads, per-bit synchronous writes.
   always @(posedge clk) begin
      if (ram_load) begin
         for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
      end else begin
         mem[ram_a_addr] <= (mem[ram_a_addr] & ~ram_a_wren) | (ram_a_wrdata & ram_a_wren);
      end
   end
   assign ram_a_rddata = mem[ram_a_addr];
   assign ram_b_rddata = mem[ram_b_addr];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n  = 1'b0;
      ram_load = 1'b1;
      tick();
      ram_load = 1'b0;
      #1;
      n_checks++;
      if (busy !== CLR_EN || core_stall !== CLR_EN) begin
         n_fail++;
         $display("FAIL reset_flags: busy=%b stall=%b required %b", busy, core_stall, CLR_EN);
      end
      n_checks++;
      if (dbg_ack !== 1'b0 || dbg_rddata !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_dbg: ack=%b rddata=%h required 0/0", dbg_ack, dbg_rddata);
      end
      reset_n = 1'b1;
`ifdef AQ32_REGFILE_CLEAR_EN
      for (int i = 0; i < 32; i++) begin
         n_checks++;
         if (busy !== 1'b1 || core_stall !== 1'b1 || ram_a_addr !== 5'(i) ||
             ram_a_wren !== 32'hFFFF_FFFF || ram_a_wrdata !== 32'h0) begin
            n_fail++;
            $display("FAIL clear_step %0d: busy=%b stall=%b addr=%0d wren=%h wrdata=%h required 1/1/%0d/ffffffff/0",
                     i, busy, core_stall, ram_a_addr, ram_a_wren, ram_a_wrdata, i);
         end
         tick();
      end
      n_checks++;
      if (busy !== 1'b0 || core_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_done: busy=%b stall=%b required 0/0", busy, core_stall);
      end
`else
      n_checks++;
      if (busy !== 1'b0 || core_stall !== 1'b0 || ram_a_wren !== 32'h0 || ram_a_addr !== 5'd0) begin
         n_fail++;
         $display("FAIL idle_after_reset: busy=%b stall=%b wren=%h addr=%0d required 0/0/0/0",
                  busy, core_stall, ram_a_wren, ram_a_addr);
      end
`endif
   endtask

   task automatic test_core_fwd();
      core_wr_en = 1'b1; core_wr_addr = 5'd5; core_wr_data = 32'hDEAD_BEEF; core_rd_addr = 5'd5;
      #1;
      n_checks++;
      if (core_rd_data !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL fwd_same_cycle: got %h required deadbeef", core_rd_data);
      end
      n_checks++;
      if (ram_a_addr !== 5'd5 || ram_a_wren !== 32'hFFFF_FFFF || core_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL core_write_port: addr=%0d wren=%h stall=%b required 5/ffffffff/0",
                  ram_a_addr, ram_a_wren, core_stall);
      end
      tick();
      core_wr_en = 1'b0;
      #1;
      n_checks++;
      if (core_rd_data !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL read_after_write: got %h required deadbeef", core_rd_data);
      end
      core_wr_en = 1'b1; core_wr_addr = 5'd6; core_wr_data = 32'h6666_6666;
      #1;
      n_checks++;
      if (core_rd_data !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL no_fwd_other_addr: got %h required deadbeef", core_rd_data);
      end
      tick();
      core_wr_addr = 5'd0; core_wr_data = 32'h1111_1111; core_rd_addr = 5'd0;
      #1;
      n_checks++;
      if (ram_a_wren !== 32'h0 || core_rd_data !== 32'h0 || core_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL x0_write: wren=%h rd=%h stall=%b required 0/0/0", ram_a_wren, core_rd_data, core_stall);
      end
      tick();
      core_wr_en = 1'b0;
      #1;
      n_checks++;
      if (core_rd_data !== 32'h0) begin
         n_fail++;
         $display("FAIL x0_read: got %h required 0", core_rd_data);
      end
      core_rd_addr = 5'd6;
      #1;
      n_checks++;
      if (core_rd_data !== 32'h6666_6666) begin
         n_fail++;
         $display("FAIL r6_read: got %h required 66666666", core_rd_data);
      end
   endtask

   task automatic test_dbg_read();
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd5;
      #1;
      n_checks++;
      if (ram_a_addr !== 5'd5 || ram_a_wren !== 32'h0 || core_stall !== 1'b0 || dbg_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL dbg_read_grant: addr=%0d wren=%h stall=%b ack=%b required 5/0/0/0",
                  ram_a_addr, ram_a_wren, core_stall, dbg_ack);
      end
      tick();
      n_checks++;
      if (dbg_ack !== 1'b1 || dbg_rddata !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL dbg_read_ack: ack=%b data=%h required 1/deadbeef", dbg_ack, dbg_rddata);
      end
      dbg_req = 1'b0;
      tick();
      n_checks++;
      if (dbg_ack !== 1'b0 || dbg_rddata !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL dbg_ack_pulse: ack=%b data=%h required 0/deadbeef", dbg_ack, dbg_rddata);
      end
      dbg_addr = 5'd0; dbg_req = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++;
         if (dbg_ack !== ((i % 2) == 0)) begin
            n_fail++;
            $display("FAIL b2b_ack cycle %0d: ack=%b required %b", i, dbg_ack, ((i % 2) == 0));
         end
      end
      n_checks++;
      if (dbg_rddata !== 32'h0) begin
         n_fail++;
         $display("FAIL dbg_x0_read: got %h required 0", dbg_rddata);
      end
      dbg_req = 1'b0;
      tick();
   endtask

   task automatic test_starve();
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd5; core_wr_en = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         core_wr_addr = 5'(9 + k);
         core_wr_data = 32'h1000_0000 + 32'(k);
         #1;
         n_checks++;
         if (k < 9) begin
            if (core_stall !== 1'b0 || ram_a_addr !== core_wr_addr) begin
               n_fail++;
               $display("FAIL starve_core_wins %0d: stall=%b addr=%0d required 0/%0d",
                        k, core_stall, ram_a_addr, core_wr_addr);
            end
         end else begin
            if (core_stall !== 1'b1 || ram_a_addr !== 5'd5 || ram_a_wren !== 32'h0) begin
               n_fail++;
               $display("FAIL starve_forced: stall=%b addr=%0d wren=%h required 1/5/0",
                        core_stall, ram_a_addr, ram_a_wren);
            end
         end
         tick();
      end
      core_wr_en = 1'b0; core_rd_addr = 5'd18;
      #1;
      n_checks++;
      if (dbg_ack !== 1'b1 || dbg_rddata !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL forced_ack: ack=%b data=%h required 1/deadbeef", dbg_ack, dbg_rddata);
      end
      n_checks++;
      if (core_rd_data !== (CLR_EN ? 32'h0 : init_val(18))) begin
         n_fail++;
         $display("FAIL stalled_write_dropped: r18=%h required %h", core_rd_data, (CLR_EN ? 32'h0 : init_val(18)));
      end
      core_wr_en = 1'b1;
      #1;
      n_checks++;
      if (core_stall !== 1'b0 || ram_a_addr !== 5'd18 || ram_a_wren !== 32'hFFFF_FFFF ||
          core_rd_data !== 32'h1000_0009) begin
         n_fail++;
         $display("FAIL ack_serves_core: stall=%b addr=%0d wren=%h rd=%h required 0/18/ffffffff/10000009",
                  core_stall, ram_a_addr, ram_a_wren, core_rd_data);
      end
      tick();
      core_wr_en = 1'b0; dbg_req = 1'b0; core_rd_addr = 5'd12;
      #1;
      n_checks++;
      if (core_rd_data !== 32'h1000_0003) begin
         n_fail++;
         $display("FAIL starve_r12: got %h required 10000003", core_rd_data);
      end
   endtask

   task automatic test_dbg_write_collision();
      core_wr_en = 1'b1; core_wr_addr = 5'd3; core_wr_data = 32'h3333_3333;
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd31; dbg_wrdata = 32'h1234_5678;
      #1;
      n_checks++;
      if (ram_a_addr !== 5'd3 || ram_a_wrdata !== 32'h3333_3333 || core_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL collision_core_wins: addr=%0d wrdata=%h stall=%b required 3/33333333/0",
                  ram_a_addr, ram_a_wrdata, core_stall);
      end
      tick();
      core_wr_en = 1'b0;
      #1;
      n_checks++;
      if (ram_a_addr !== 5'd31 || ram_a_wren !== 32'hFFFF_FFFF || ram_a_wrdata !== 32'h1234_5678 ||
          dbg_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL dbg_write_grant: addr=%0d wren=%h wrdata=%h ack=%b required 31/ffffffff/12345678/0",
                  ram_a_addr, ram_a_wren, ram_a_wrdata, dbg_ack);
      end
      tick();
      n_checks++;
      if (dbg_ack !== 1'b1) begin
         n_fail++;
         $display("FAIL dbg_write_ack: ack=%b required 1", dbg_ack);
      end
      dbg_req = 1'b0; core_rd_addr = 5'd31;
      #1;
      n_checks++;
      if (core_rd_data !== 32'h1234_5678) begin
         n_fail++;
         $display("FAIL r31_readback: got %h required 12345678", core_rd_data);
      end
      core_rd_addr = 5'd3;
      #1;
      n_checks++;
      if (core_rd_data !== 32'h3333_3333) begin
         n_fail++;
         $display("FAIL r3_readback: got %h required 33333333", core_rd_data);
      end
      tick();
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd0; dbg_wrdata = 32'hFFFF_FFFF;
      #1;
      n_checks++;
      if (ram_a_addr !== 5'd0 || ram_a_wren !== 32'h0) begin
         n_fail++;
         $display("FAIL dbg_x0_write: addr=%0d wren=%h required 0/0", ram_a_addr, ram_a_wren);
      end
      tick();
      n_checks++;
      if (dbg_ack !== 1'b1) begin
         n_fail++;
         $display("FAIL dbg_x0_ack: ack=%b required 1", dbg_ack);
      end
      dbg_req = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_ack();
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd31;
      tick();
      n_checks++;
      if (dbg_ack !== 1'b1 || dbg_rddata !== 32'h1234_5678) begin
         n_fail++;
         $display("FAIL pre_reset_ack: ack=%b data=%h required 1/12345678", dbg_ack, dbg_rddata);
      end
      #1;
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (dbg_ack !== 1'b0 || dbg_rddata !== 32'h0 || busy !== CLR_EN) begin
         n_fail++;
         $display("FAIL reset_drops_ack: ack=%b data=%h busy=%b required 0/0/%b", dbg_ack, dbg_rddata, busy, CLR_EN);
      end
      dbg_req = 1'b0;
      tick();
      reset_n = 1'b1;
`ifdef AQ32_REGFILE_CLEAR_EN
      repeat (32) tick();
`endif
      #1;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_after_reclear: got %b required 0", busy);
      end
`ifdef AQ32_REGFILE_CLEAR_EN
      for (int i = 0; i < 32; i++) begin
         core_rd_addr = 5'(i);
         #1;
         n_checks++;
         if (core_rd_data !== 32'h0) begin
            n_fail++;
            $display("FAIL cleared_r%0d: got %h required 0", i, core_rd_data);
         end
      end
`else
      core_rd_addr = 5'd0;
      #1;
      n_checks++;
      if (core_rd_data !== 32'h0) begin
         n_fail++;
         $display("FAIL x0_after_reset: got %h required 0", core_rd_data);
      end
`endif
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd31;
      tick();
      n_checks++;
      if (dbg_ack !== 1'b1 || dbg_rddata !== (CLR_EN ? 32'h0 : 32'h1234_5678)) begin
         n_fail++;
         $display("FAIL post_reset_dbg_read: ack=%b data=%h required 1/%h",
                  dbg_ack, dbg_rddata, (CLR_EN ? 32'h0 : 32'h1234_5678));
      end
      dbg_req = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_core_fwd();
      test_dbg_read();
      test_starve();
      test_dbg_write_collision();
      test_reset_mid_ack();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/aq32_regfile_ctrl.md
# aq32_regfile_ctrl

Sequencer and arbiter for the aq32 32-entry, 32-bit dual-port distributed-RAM register file. After reset it zero-fills all 32 entries. It then shares the single read/write port A between the core writeback path and a debug access port, and serves the core's read-only port B with x0 masking and same-cycle write forwarding. It sits between the aq32 pipeline/debug unit and the RAM wrapper, driving every RAM input.

## Interface
- WIDTH, 32, data width; must be a multiple of 8.
- STARVE_LIMIT, 8, consecutive denied debug cycles before debug is force-granted; range 1..255.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- busy  out  1  high while the clear sequence runs.
- core_stall  out  1  core must hold writeback; write not performed this cycle.
- core_wr_en  in  1  core writeback request.
- core_wr_addr  in  5  writeback register index.
- core_wr_data  in  WIDTH  writeback data.
- core_rd_addr  in  5  core read index, routed to port B.
- core_rd_data  out  WIDTH  core read data; combinational.
- dbg_req  in  1  debug access request; held until dbg_ack.
- dbg_we  in  1  1 = write, 0 = read.
- dbg_addr  in  5  debug register index.
- dbg_wrdata  in  WIDTH  debug write data.
- dbg_ack  out  1  one-cycle completion pulse.
- dbg_rddata  out  WIDTH  registered read result; valid with dbg_ack, held until the next read.
- ram_a_addr  out  5  RAM port A address.
- ram_a_wrdata  out  WIDTH  RAM port A write data.
- ram_a_wren  out  WIDTH  per-bit write enables; driven all-ones or all-zeros.
- ram_a_rddata  in  WIDTH  RAM port A asynchronous read data.
- ram_b_addr  out  5  RAM port B address, equal to core_rd_addr.
- ram_b_rddata  in  WIDTH  RAM port B asynchronous read data.

## Operation
- States: CLEAR, RUN, ACK.
- CLEAR:
  - clr_cnt counts 0..31; port A writes 0 to address clr_cnt.
  - busy=1 and core_stall=1.
  - After the clr_cnt=31 write, go to RUN.
- RUN, port A grant priority:
  - Forced debug, when dbg_req=1 and starve_cnt ≥ STARVE_LIMIT: debug takes port A and core_stall=1.
  - Core, when core_wr_en=1: core takes port A.
  - Debug, otherwise when dbg_req=1: debug takes port A.
- Debug grant:
  - Port A uses dbg_addr.
  - For a write, port A write enables are all-ones.
  - For a read, dbg_rddata ← ram_a_rddata at the clock edge.
  - Next state is ACK.
- ACK: dbg_ack=1 for exactly one cycle. Core writes are still served in ACK; debug is not. Next state is RUN.
- starve_cnt:
  - Increments (saturating) each RUN cycle with dbg_req=1 and no debug grant.
  - Clears on a debug grant, and whenever dbg_req=0.
- x0 rules:
  - Writes to address 0 from core or debug are suppressed: wren=0, but grant, ack and stall behave as for any other address.
  - core_rd_data is 0 when core_rd_addr=0. A debug read of 0 returns 0.
- Forwarding: if core_wr_en=1, the core is granted, core_wr_addr=core_rd_addr≠0, then core_rd_data=core_wr_data; otherwise core_rd_data=ram_b_rddata.
- No grant: ram_a_wren=0 and ram_a_addr=0.

## Timing
- Reset values:
  - state=CLEAR, clr_cnt=0, starve_cnt=0.
  - dbg_ack=0, dbg_rddata=0.
  - busy=1, core_stall=1.
- Clear takes exactly 32 cycles after reset_n deasserts. busy falls at the edge that ends the 32nd cycle.
- Debug latency: a request granted in cycle N gives dbg_ack in cycle N+1. Minimum 2 cycles between successive debug accesses.
- core_stall is combinational from dbg_req and starve_cnt in RUN; it is 1 throughout CLEAR.
- Port B reads and core_rd_data have zero latency.
- reset_n asserted mid-access: immediate return to CLEAR. Any pending ack is dropped; the debug master must reissue the request.
- dbg_req dropped before ack: the access may already have been performed. The block does not define this.

## Configuration
- AQ32_REGFILE_CLEAR_EN defined: CLEAR state and 32-cycle zero-fill as above.
- Not defined:
  - Reset enters RUN directly; busy is tied 0.
  - Register contents after reset are undefined, except that x0 always reads 0.

## Structure
- Package aq32_regfile_pkg holds:
  - REG_ADDR_W=5 and REG_COUNT=32.
  - The state enum (CLEAR, RUN, ACK).
  - Grant encoding (NONE, CORE, DBG, CLR).
- Sub-module aq32_regfile_arb contains the grant decision and starve_cnt. The top level owns the state machine, clr_cnt, port A/B muxing, forwarding and dbg_rddata.

## Test plan
- Reset then idle: busy high for 32 cycles; ram_a_addr steps 0..31 with wren all-ones and wrdata 0; busy low on cycle 33.
- Core writes 0xDEADBEEF to r5 while reading r5 in the same cycle: core_rd_data=0xDEADBEEF that cycle and from RAM on the next cycle. Writing r0 gives wren=0, and a read of r0 returns 0.
- Debug read of r5 with core idle: dbg_ack one cycle after grant, dbg_rddata=0xDEADBEEF. Back-to-back requests ack every 2nd cycle.
- Core writes every cycle with dbg_req held and STARVE_LIMIT=8: debug is force-granted on the 9th request cycle with core_stall=1 for that cycle only, and the core write is not performed.
- Debug write 0x12345678 to r31 in the same cycle as a core write: core wins, debug is granted next RUN cycle, r31 reads 0x12345678.
- reset_n pulsed low during ACK: dbg_ack goes to 0 immediately, the clear sequence restarts, and all registers read 0 afterwards.
